// File: rtl/oneapi_avs_packet_arbiter_if.sv
// Avalon-ST pixel stream bundle shared by both sinks and the source of the
// packet arbiter.
//   valid, data, empty, startofpacket, endofpacket : producer -> consumer
//   ready                                          : consumer -> producer (readyLatency 0)
// The master modport is the producing side and the slave modport is the consuming side.
interface oneapi_avs_packet_arbiter_if #(
    parameter int BITS_AV    = 256,
    parameter int EMPTY_BITS = 5
);
    logic                  valid;
    logic                  ready;
    logic [BITS_AV-1:0]    data;
    logic [EMPTY_BITS-1:0] empty;
    logic                  startofpacket;
    logic                  endofpacket;

    modport master (output valid, data, empty, startofpacket, endofpacket, input ready);
    modport slave  (input valid, data, empty, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/oneapi_avs_packet_arbiter.sv
// Packet-granular round-robin arbiter. Two Avalon-ST producers share one
// pixel stream that feeds the Avalon-to-AXI4-Stream gasket. A grant is held
// from the head beat of a packet until its EOP beat is accepted, so packets
// are never interleaved.
// Ports:
//   csi_clk, rsi_reset   clock and synchronous active-high reset
//   asi0, asi1           sink streams (slave side of the stream bundle)
//   aso                  source stream toward the gasket (master side)
//   csr_pause            level input; no new grant is issued while it is high
//   csr_clear            pulse input; clears the packet counters and error flags
//   csr_idle             high while no port holds a grant
//   csr_pkt_count0/1     packets completed on each port (wrapping)
//   csr_err_nosop        sticky flag per port: the head beat of a grant lacked SOP
//   csr_err_midsop       sticky flag per port: SOP was seen on a non-head beat
module oneapi_avs_packet_arbiter #(
    parameter int BITS_AV    = 256,
    parameter int EMPTY_BITS = 5,
    parameter int CNT_BITS   = 16
) (
    input  logic                          csi_clk,
    input  logic                          rsi_reset,
    oneapi_avs_packet_arbiter_if.slave    asi0,
    oneapi_avs_packet_arbiter_if.slave    asi1,
    oneapi_avs_packet_arbiter_if.master   aso,
    input  logic                          csr_pause,
    input  logic                          csr_clear,
    output logic                          csr_idle,
    output logic [CNT_BITS-1:0]           csr_pkt_count0,
    output logic [CNT_BITS-1:0]           csr_pkt_count1,
    output logic [1:0]                    csr_err_nosop,
    output logic [1:0]                    csr_err_midsop
);
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    state_t                state;
    logic                  last;        // port that completed the most recent packet
    logic                  first;       // next accepted beat is the packet head

    logic                  granted;
    logic                  sel;         // port currently steering the source mux
    logic                  sel_valid;
    logic                  sel_sop;
    logic                  sel_eop;
    logic [BITS_AV-1:0]    sel_data;
    logic [EMPTY_BITS-1:0] sel_empty;
    logic                  accept;
    logic                  grant_next;  // port to grant when leaving IDLE

    always_comb begin
        granted = (state != IDLE);
        // In IDLE the mux rests on the last granted port, so data/empty show its inputs.
        sel       = (state == GRANT1) || ((state == IDLE) && last);
        sel_valid = sel ? asi1.valid         : asi0.valid;
        sel_sop   = sel ? asi1.startofpacket : asi0.startofpacket;
        sel_eop   = sel ? asi1.endofpacket   : asi0.endofpacket;
        sel_data  = sel ? asi1.data          : asi0.data;
        sel_empty = sel ? asi1.empty         : asi0.empty;

        aso.valid         = granted && sel_valid;
        aso.startofpacket = granted && sel_sop;
        aso.endofpacket   = granted && sel_eop;
        aso.data          = sel_data;
        aso.empty         = sel_empty;

        asi0.ready = (state == GRANT0) && aso.ready;
        asi1.ready = (state == GRANT1) && aso.ready;

        accept = granted && sel_valid && aso.ready;

        // On a tie the port that did not go last wins; otherwise the lone requester.
        grant_next = (asi0.valid && asi1.valid) ? ~last : asi1.valid;

        csr_idle = (state == IDLE);
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state          <= IDLE;
            last           <= 1'b1;
            first          <= 1'b0;
            csr_pkt_count0 <= '0;
            csr_pkt_count1 <= '0;
            csr_err_nosop  <= 2'b00;
            csr_err_midsop <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (!csr_pause && (asi0.valid || asi1.valid)) begin
                        state <= grant_next ? GRANT1 : GRANT0;
                        first <= 1'b1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (accept) begin
                        first <= 1'b0;
                        if (sel_eop) begin
                            state <= IDLE;
                            last  <= sel;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Clear has priority over any increment or flag set in the same cycle.
            if (csr_clear) begin
                csr_pkt_count0 <= '0;
                csr_pkt_count1 <= '0;
                csr_err_nosop  <= 2'b00;
                csr_err_midsop <= 2'b00;
            end else if (accept) begin
                if (first && !sel_sop) csr_err_nosop[sel] <= 1'b1;
                if (!first && sel_sop) csr_err_midsop[sel] <= 1'b1;
                if (sel_eop) begin
                    if (sel) csr_pkt_count1 <= csr_pkt_count1 + CNT_ONE;
                    else     csr_pkt_count0 <= csr_pkt_count0 + CNT_ONE;
                end
            end
        end
    end
endmodule

// File: doc/oneapi_avs_packet_arbiter.md
# oneapi_avs_packet_arbiter

Packet-granular round-robin arbiter that shares one Avalon-ST pixel stream between two upstream producers and feeds it into the Avalon-to-AXI4-Stream pixel gasket. A grant is held from the first beat of a packet until its end-of-packet beat is accepted, so frames are never interleaved. Pause, idle, per-port packet counters and sticky framing-error flags are exposed so the host can change stream configuration only at packet boundaries.

## Interface
Parameters:
- BITS_AV, 256, Avalon data width (PARALLEL_PIXELS × CHANNELS × power-of-2 channel width)
- EMPTY_BITS, 5, width of empty field, $clog2(BITS_AV/8)
- CNT_BITS, 16, width of each packet counter

Ports:
- csi_clk  in  1  sole clock
- rsi_reset  in  1  synchronous, active-high reset
- asi0_valid / asi1_valid  in  1  sink n valid
- asi0_ready / asi1_ready  out  1  sink n ready (readyLatency 0)
- asi0_data / asi1_data  in  BITS_AV  sink n data
- asi0_empty / asi1_empty  in  EMPTY_BITS  sink n empty
- asi0_startofpacket / asi1_startofpacket  in  1  sink n SOP
- asi0_endofpacket / asi1_endofpacket  in  1  sink n EOP
- aso_valid  out  1  source valid, to gasket asi_valid
- aso_ready  in  1  source ready, from gasket asi_ready
- aso_data  out  BITS_AV  source data
- aso_empty  out  EMPTY_BITS  source empty
- aso_startofpacket  out  1  source SOP
- aso_endofpacket  out  1  source EOP
- csr_pause  in  1  level; blocks new grants
- csr_clear  in  1  pulse; clears counters and error flags
- csr_idle  out  1  high in IDLE state
- csr_pkt_count0 / csr_pkt_count1  out  CNT_BITS  packets completed per port
- csr_err_nosop  out  2  sticky per port: first beat of grant lacked SOP
- csr_err_midsop  out  2  sticky per port: SOP seen on non-first beat

## Operation
- State machine: IDLE, GRANT0, GRANT1. Registered `last` (last granted port) and `first` (next accepted beat is packet head) flags.
- IDLE: if csr_pause=0 and any asiN_valid, grant in the next cycle. If both are valid, grant the port ≠ `last`; otherwise grant the single requester. Set `first`=1.
- GRANTn: aso_* = asin_* (combinational mux); aso_valid = asin_valid; asin_ready = aso_ready; the other sink's ready = 0.
- Accept = aso_valid & aso_ready. On accept, `first` is cleared.
- On an accept with EOP: go to IDLE, set `last`=n, and increment csr_pkt_countn. The counter wraps at 2^CNT_BITS.
- Framing checks on accept:
  - `first`=1 and SOP=0 sets csr_err_nosop[n]. The data is still forwarded.
  - `first`=0 and SOP=1 sets csr_err_midsop[n]. The packet continues and the grant is not restarted.
- csr_pause asserted mid-packet does not affect the current packet. The grant is released at EOP and no new grant is issued while the pause is held.
- csr_clear zeroes the counters and error flags. If an increment or set occurs in the same cycle, clear wins.
- A single-beat packet (SOP & EOP on one beat) is legal. It increments the counter and returns to IDLE.

## Timing
- Reset values:
  - State = IDLE, `last`=1 (so port 0 wins the first tie), `first`=0.
  - aso_valid=0, asi0_ready=asi1_ready=0, csr_idle=1, counters=0, errors=0.
- In IDLE:
  - aso_valid, aso_startofpacket, aso_endofpacket, asi0_ready and asi1_ready are all 0.
  - aso_data and aso_empty show the `last` port's inputs.
- Grant latency: 1 cycle from valid seen in IDLE to aso_valid. There is 1 IDLE bubble cycle between consecutive packets.
- Data path adds 0 cycles of latency. aso_ready → asin_ready is a combinational path.
- Back-to-back packets from the same port while the other port is idle are re-granted after the bubble. Sustained throughput is N/(N+1) beats per cycle for N-beat packets.
- Reset asserted mid-packet takes effect at the next edge. The packet is abandoned with no EOP emitted downstream, and counters and flags clear.

## Test plan
- Port 0 sends a 4-beat packet, port 1 idle, aso_ready=1 → aso_valid high cycles 2–5 after first valid; SOP on beat 1, EOP on beat 4; csr_pkt_count0=1; csr_idle back to 1.
- Both ports present continuous 3-beat packets from reset → grant order 0,1,0,1; no beat of one packet lies between SOP and EOP of another; counts 2/2 after 4 packets.
- aso_ready toggles 1,0,1,0 during a port-1 packet → asi1_ready mirrors aso_ready each cycle and asi0_ready stays 0; no beat is duplicated or dropped (compare data 0x…11..0x…44 pattern).
- csr_pause raised on beat 2 of a port-0 packet while port 1 is valid → port-0 packet completes, csr_idle=1, no grant while paused; port 1 is granted 1 cycle after pause drops.
- Port 0 first beat without SOP, then a SOP on beat 3 → csr_err_nosop=2'b01 and csr_err_midsop=2'b01; a csr_clear pulse coincident with the EOP accept leaves count0=0 and errors=0.
- Reset asserted on beat 2 of a 5-beat packet → next cycle aso_valid=0, both readies 0, csr_idle=1, counters 0; a new packet after reset is granted to port 0 on a tie.
